// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl
// Purpose  : Round-robin controller that time-shares one 4x4 multiplier
//            between NUM_REQ requesters. Results go out on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================

module multiplier_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  assign p_o = {4'd0, a_i} * {4'd0, b_i};
endmodule

module mult_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [7:0]             resp_product,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [ID_W:0]   c_NUM_REQ = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ-1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      cur_id_q, resp_id_q;
  logic [3:0]           op_a_q, op_b_q;
  logic [7:0]           resp_product_q;
  logic [7:0]           mul_p;
  logic [ID_W-1:0]      win_id;
  logic [3:0]           win_a, win_b;
  logic [NUM_REQ-1:0]   grant;
  logic                 found;
  logic                 hs;

  // Search from rr_ptr upward, wrapping at NUM_REQ; first valid index wins.
  always_comb begin : arb
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] idx_t;
    found = 1'b0;
    win_id = '0;
    grant = '0;
    idx = '0;
    idx_t = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= c_NUM_REQ) begin
        idx = idx - c_NUM_REQ;
      end
      idx_t = idx[ID_W-1:0];
      if (!found && req_valid[idx_t]) begin
        found = 1'b1;
        win_id = idx_t;
        grant[idx_t] = 1'b1;
      end
    end
  end

  assign win_a = req_a[{win_id, 2'b00} +: 4];
  assign win_b = req_b[{win_id, 2'b00} +: 4];
  assign hs    = (state_q == S_IDLE) && found;

  multiplier_4bit u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_MUL;
          rr_ptr_d = (win_id == c_LAST_ID) ? '0 : win_id + 1'b1;
        end
      end
      S_MUL:   state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      cur_id_q       <= '0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (hs) begin
        op_a_q   <= win_a;
        op_b_q   <= win_b;
        cur_id_q <= win_id;
      end
      if (state_q == S_MUL) begin
        resp_product_q <= mul_p;
        resp_id_q      <= cur_id_q;
      end
    end
  end

  // Grant is gated by rst_n so it drops the instant reset asserts.
  assign req_ready    = (state_q == S_IDLE && rst_n) ? grant : '0;
  assign resp_valid   = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;

endmodule
`default_nettype wire
